// File: rtl/instruction_decoder_pkg.sv
// Shared encoding constants for the instruction decoder and the datapath.
// Field positions, opcode patterns and source-select codes live here only.
package instruction_decoder_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned REG_CNT = 8;

  // 8-bit instruction formats:
  // LOAD 0ddd_cccc | MOV 10dd_dsss | ALU 110r_ffff | JMP 1110_aaaa | JNZ 1111_aaaa
  localparam int unsigned LOAD_D_MSB = 6;
  localparam int unsigned LOAD_D_LSB = 4;
  localparam int unsigned MOV_D_MSB  = 5;
  localparam int unsigned MOV_D_LSB  = 3;
  localparam int unsigned MOV_S_MSB  = 2;
  localparam int unsigned MOV_S_LSB  = 0;
  localparam int unsigned ALU_R_BIT  = 4;
  localparam int unsigned NIB_MSB    = 3;
  localparam int unsigned NIB_LSB    = 0;

  localparam logic [0:0] OPC_LOAD = 1'b0;
  localparam logic [1:0] OPC_MOV  = 2'b10;
  localparam logic [2:0] OPC_ALU  = 3'b110;
  localparam logic [3:0] OPC_JMP  = 4'b1110;
  localparam logic [3:0] OPC_JNZ  = 4'b1111;

  localparam logic [3:0] SRC_IMM = 4'd8;
  localparam logic [3:0] SRC_ALU = 4'd9;
  localparam logic [3:0] ALU_NOP = 4'd0;

  typedef enum logic [2:0] {
    CLS_LOAD,
    CLS_MOV,
    CLS_ALU,
    CLS_JMP,
    CLS_JNZ
  } instr_cls_e;

  function automatic instr_cls_e classify(input logic [INSTR_W-1:0] instr);
    instr_cls_e cls;
    if (instr[7:7] == OPC_LOAD)      cls = CLS_LOAD;
    else if (instr[7:6] == OPC_MOV)  cls = CLS_MOV;
    else if (instr[7:5] == OPC_ALU)  cls = CLS_ALU;
    else if (instr[7:4] == OPC_JMP)  cls = CLS_JMP;
    else                             cls = CLS_JNZ;
    return cls;
  endfunction

endpackage

// File: rtl/instruction_decoder_reset_sync.sv
// Two-flop reset synchroniser: asserts immediately on reset_n low, releases
// on the second rising clk edge after reset_n returns high.
module reset_sync (
  input  logic clk,
  input  logic reset_n,
  output logic sync_reset
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign sync_reset = sync_q;

endmodule

// File: rtl/instruction_decoder.sv
// Single-cycle instruction decoder: combinational decode of pm_data into
// register enables, source/ALU selects and jump requests, plus zero flag and ir.
module instruction_decoder
  import instruction_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [INSTR_W-1:0]   pm_data,
  input  logic                 alu_zero,
  output logic                 sync_reset,
  output logic                 jmp,
  output logic                 jmp_nz,
  output logic [3:0]           jmp_addr,
  output logic                 dont_jmp,
  output logic [REG_CNT-1:0]   reg_en,
  output logic [3:0]           src_sel,
  output logic [3:0]           imm,
  output logic [3:0]           alu_func,
  output logic [INSTR_W-1:0]   ir
);

  logic                z_q, z_d;
  logic [INSTR_W-1:0]  ir_q;
  logic                z_upd;
  instr_cls_e          cls;
  logic [2:0]          mov_d, mov_s, load_d;
  logic [3:0]          nib;

  reset_sync u_reset_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset)
  );

  assign cls    = classify(pm_data);
  assign load_d = pm_data[LOAD_D_MSB:LOAD_D_LSB];
  assign mov_d  = pm_data[MOV_D_MSB:MOV_D_LSB];
  assign mov_s  = pm_data[MOV_S_MSB:MOV_S_LSB];
  assign nib    = pm_data[NIB_MSB:NIB_LSB];

  // sync_reset follows reset_n asynchronously, so gating on it alone is
  // enough to clear every decode output the moment reset_n drops.
  always_comb begin
    jmp      = 1'b0;
    jmp_nz   = 1'b0;
    jmp_addr = 4'd0;
    reg_en   = '0;
    src_sel  = 4'd0;
    imm      = 4'd0;
    alu_func = ALU_NOP;
    z_upd    = 1'b0;
    if (!sync_reset) begin
      jmp_addr = nib;
      imm      = nib;
      unique case (cls)
        CLS_LOAD: begin
          reg_en[load_d] = 1'b1;
          src_sel        = SRC_IMM;
        end
        CLS_MOV: begin
          if (mov_d != mov_s) begin
            reg_en[mov_d] = 1'b1;
            src_sel       = {1'b0, mov_s};
          end
        end
        CLS_ALU: begin
          if (nib != ALU_NOP) begin
            reg_en[{2'b00, pm_data[ALU_R_BIT]}] = 1'b1;
            src_sel  = SRC_ALU;
            alu_func = nib;
            z_upd    = 1'b1;
          end
        end
        CLS_JMP: jmp    = 1'b1;
        CLS_JNZ: jmp_nz = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    z_d = z_q;
    if (sync_reset)  z_d = 1'b0;
    else if (z_upd)  z_d = alu_zero;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z_q  <= 1'b0;
      ir_q <= '0;
    end else begin
      z_q  <= z_d;
      ir_q <= sync_reset ? '0 : pm_data;
    end
  end

  assign dont_jmp = z_q;
  assign ir       = ir_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed-vector bench for instruction_decoder with hand-computed expectations.
module tb_instruction_decoder;

  logic       clk;
  logic       reset_n;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic [7:0] reg_en;
  logic [3:0] src_sel;
  logic [3:0] imm;
  logic [3:0] alu_func;
  logic [7:0] ir;

  int vectors;
  int miscompares;

  instruction_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pm_data    (pm_data),
    .alu_zero   (alu_zero),
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .dont_jmp   (dont_jmp),
    .reg_en     (reg_en),
    .src_sel    (src_sel),
    .imm        (imm),
    .alu_func   (alu_func),
    .ir         (ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic decode_chk(input string tag, input logic [7:0] e_reg_en, input logic [3:0] e_src,
                            input logic [3:0] e_func, input logic e_jmp, input logic e_jnz);
    check({tag, ".reg_en"},   reg_en,             e_reg_en);
    check({tag, ".src_sel"},  {4'h0, src_sel},    {4'h0, e_src});
    check({tag, ".alu_func"}, {4'h0, alu_func},   {4'h0, e_func});
    check({tag, ".jmp"},      {7'h0, jmp},        {7'h0, e_jmp});
    check({tag, ".jmp_nz"},   {7'h0, jmp_nz},     {7'h0, e_jnz});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    pm_data     = 8'h5A;
    alu_zero    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.sync_reset", {7'h0, sync_reset}, 8'h01);
    check("rst.dont_jmp",   {7'h0, dont_jmp},   8'h00);
    check("rst.ir",         ir,                 8'h00);
    decode_chk("rst", 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel1.sync_reset", {7'h0, sync_reset}, 8'h01);
    @(negedge clk);
    check("rel2.sync_reset", {7'h0, sync_reset}, 8'h00);
    check("rel2.ir",         ir,                 8'h00);
    check("rel2.dont_jmp",   {7'h0, dont_jmp},   8'h00);

    // LOAD 5A: d=5, c=A
    decode_chk("load5A", 8'h20, 4'd8, 4'd0, 1'b0, 1'b0);
    check("load5A.imm", {4'h0, imm}, 8'h0A);
    @(negedge clk);
    check("load5A.ir", ir, 8'h5A);

    pm_data = 8'h0F; #1;
    decode_chk("load0F", 8'h01, 4'd8, 4'd0, 1'b0, 1'b0);
    check("load0F.imm", {4'h0, imm}, 8'h0F);
    pm_data = 8'h70; #1;
    decode_chk("load70", 8'h80, 4'd8, 4'd0, 1'b0, 1'b0);
    check("load70.imm", {4'h0, imm}, 8'h00);

    pm_data = 8'h9B; #1;
    decode_chk("mov33", 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    pm_data = 8'h99; #1;
    decode_chk("mov31", 8'h08, 4'd1, 4'd0, 1'b0, 1'b0);
    pm_data = 8'h87; #1;
    decode_chk("mov07", 8'h01, 4'd7, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("mov07.ir", ir, 8'h87);

    // ALU D3 (r=1, f=3) with alu_zero=1, then JNZ F7 sees the new flag
    pm_data  = 8'hD3;
    alu_zero = 1'b1; #1;
    decode_chk("aluD3", 8'h02, 4'd9, 4'd3, 1'b0, 1'b0);
    check("aluD3.dont_jmp", {7'h0, dont_jmp}, 8'h00);
    @(negedge clk);
    pm_data  = 8'hF7;
    alu_zero = 1'b0; #1;
    decode_chk("jnzF7", 8'h00, 4'd0, 4'd0, 1'b0, 1'b1);
    check("jnzF7.jmp_addr", {4'h0, jmp_addr}, 8'h07);
    check("jnzF7.dont_jmp", {7'h0, dont_jmp}, 8'h01);
    @(negedge clk);
    check("jnzF7.hold", {7'h0, dont_jmp}, 8'h01);

    // ALU C5 (r=0, f=5) with alu_zero=0 clears z
    pm_data = 8'hC5; #1;
    decode_chk("aluC5", 8'h01, 4'd9, 4'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("aluC5.dont_jmp", {7'h0, dont_jmp}, 8'h00);

    // ALU NOP C0 must not update z even with alu_zero=1
    pm_data  = 8'hC0;
    alu_zero = 1'b1; #1;
    decode_chk("aluC0", 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("aluC0.dont_jmp", {7'h0, dont_jmp}, 8'h00);

    // set z=1 again so the async reset has something to clear
    pm_data = 8'hD2; #1;
    @(negedge clk);
    check("aluD2.dont_jmp", {7'h0, dont_jmp}, 8'h01);
    check("aluD2.ir",       ir,               8'hD2);

    pm_data  = 8'hE4;
    alu_zero = 1'b0; #1;
    decode_chk("jmpE4", 8'h00, 4'd0, 4'd0, 1'b1, 1'b0);
    check("jmpE4.jmp_addr", {4'h0, jmp_addr}, 8'h04);
    #1 reset_n = 1'b0;
    #1;
    check("midrst.jmp",        {7'h0, jmp},        8'h00);
    check("midrst.sync_reset", {7'h0, sync_reset}, 8'h01);
    check("midrst.jmp_addr",   {4'h0, jmp_addr},   8'h00);
    check("midrst.dont_jmp",   {7'h0, dont_jmp},   8'h00);
    check("midrst.ir",         ir,                 8'h00);
    check("midrst.imm",        {4'h0, imm},        8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset_n  input  1  asynchronous active-low reset.
REQ-002 pm_data  input  8  instruction word from program memory for the current pc, valid combinationally within the cycle.
REQ-003 alu_zero  input  1  ALU result-is-zero indication for the instruction currently in pm_data.
REQ-004 sync_reset  output  1  synchronised reset to the program sequencer and datapath, active high.
REQ-005 jmp, jmp_nz  output  1 each  unconditional / conditional jump requests to the program sequencer.
REQ-006 jmp_addr  output  4  jump target nibble, equal to pm_data[3:0].
REQ-007 dont_jmp  output  1  registered zero flag; 1 suppresses jmp_nz in the sequencer.
REQ-008 reg_en  output  8  one-hot register load enables, registers 0..7.
REQ-009 src_sel  output  4  datapath source: 0-7 register, 8 immediate, 9 ALU result.
REQ-010 imm  output  4  immediate operand, equal to pm_data[3:0].
REQ-011 alu_func  output  4  ALU function code.
REQ-012 ir  output  8  registered copy of the last decoded instruction (debug).

Function
REQ-013 Encoding SHALL be: LOAD 0ddd_cccc; MOV 10dd_dsss; ALU 110r_ffff; JMP 1110_aaaa; JNZ 1111_aaaa.
REQ-014 LOAD SHALL assert reg_en[d], src_sel=8, imm=cccc, in the same cycle as pm_data.
REQ-015 MOV SHALL assert reg_en[d], src_sel={0,sss}; MOV with d==s SHALL be a NOP (reg_en=0).
REQ-016 ALU SHALL assert reg_en[r] (register 0 or 1), src_sel=9, alu_func=ffff; ffff=0 SHALL be a NOP (reg_en=0, flag unchanged).
REQ-017 JMP SHALL assert jmp=1; JNZ SHALL assert jmp_nz=1; both drive jmp_addr=aaaa; neither asserts any reg_en.
REQ-018 Decode outputs (jmp, jmp_nz, jmp_addr, reg_en, src_sel, imm, alu_func) SHALL be combinational from pm_data, zero latency.
REQ-019 For non-decoding cases, src_sel and alu_func SHALL be 0.
REQ-020 Zero flag z SHALL update on the rising edge from alu_zero only for ALU instructions with ffff!=0; otherwise hold; dont_jmp = z.
REQ-021 An ALU instruction and a following JNZ SHALL see the new flag (one-cycle flag latency).
REQ-022 ir SHALL capture pm_data every rising edge while sync_reset=0.
REQ-023 While sync_reset=1, all decode outputs SHALL be forced to 0 and z and ir SHALL hold 0.

Reset
REQ-024 reset_n low SHALL asynchronously set sync_reset=1, z=0, ir=8'h00.
REQ-025 sync_reset SHALL deassert synchronously on the second rising edge after reset_n rises (2-flop synchroniser).
REQ-026 reset_n reasserted mid-operation SHALL immediately force sync_reset=1 and all outputs to reset values, regardless of the current instruction.

Structure
REQ-027 Opcode field positions, opcode constants, src_sel codes (SRC_IMM=8, SRC_ALU=9) and ALU_NOP=0 SHALL live in a shared package used by decoder and datapath.
REQ-028 The reset synchroniser SHALL be a separate sub-module, reset_sync.

Verification
REQ-029 reset_n low 3 cycles then high -> sync_reset=1 until second edge after release, then 0; z=0, ir=00.
REQ-030 pm_data=8'h5A -> reg_en=8'h20, src_sel=8, imm=4'hA, jmp=0.
REQ-031 pm_data=8'h9B (MOV d=3,s=3) -> reg_en=0; pm_data=8'h99 (d=3,s=1) -> reg_en=8'h08, src_sel=1.
REQ-032 pm_data=8'hD3 with alu_zero=1, next pm_data=8'hF7 -> first cycle reg_en=8'h02, src_sel=9, alu_func=3; next cycle jmp_nz=1, jmp_addr=7, dont_jmp=1.
REQ-033 pm_data=8'hC0 with alu_zero=1 after z=0 -> reg_en=0, dont_jmp stays 0.
REQ-034 pm_data=8'hE4 with reset_n dropped mid-cycle -> jmp falls to 0 and sync_reset rises without waiting for clk.
